// File: rtl/mult_div_unit_pkg.sv
//==============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared definitions for the multiply/divide unit.
//               - funct codes for the HI/LO instruction class (shared with the
//                 alu and control unit)
//               - FSM state encoding (IDLE/CALC/FIX)
//               - divide-by-zero quotient fill value
//               - helper decode function
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mult_div_unit_pkg;

    // funct field encodings
    localparam logic [5:0] c_FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] c_FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] c_FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] c_FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] c_FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] c_FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] c_FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] c_FUNCT_DIVU  = 6'b011011;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_CALC = 2'd1;
    localparam state_t c_ST_FIX  = 2'd2;

    // Divide by zero yields an all-ones quotient; this is the fill bit.
    localparam logic c_DIV0_FILL = 1'b1;

    // True for the four iterative (HI/LO producing) operations.
    function automatic logic is_md_op(input logic [5:0] op);
        return (op == c_FUNCT_MULT) || (op == c_FUNCT_MULTU) ||
               (op == c_FUNCT_DIV)  || (op == c_FUNCT_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_if.sv
//==============================================================================
// Module      : mult_div_unit_if
// Description : EX-stage operand/result bundle shared by the alu and the
//               multiply/divide unit.
//               master : EX stage driver (Start, Operation, DataA, DataB)
//               slave  : responder (Busy, Done, Stall, Result)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             Start;
    logic [5:0]       Operation;
    logic [WIDTH-1:0] DataA;
    logic [WIDTH-1:0] DataB;
    logic             Busy;
    logic             Done;
    logic             Stall;
    logic [WIDTH-1:0] Result;

    modport master (
        output Start, Operation, DataA, DataB,
        input  Busy, Done, Stall, Result
    );

    modport slave (
        input  Start, Operation, DataA, DataB,
        output Busy, Done, Stall, Result
    );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit_seq_core.sv
//==============================================================================
// Module      : mdu_seq_core
// Description : Unsigned iterative datapath, one bit per step.
//               Multiply : LSB-first shift-add, {hi,lo} shifts right.
//               Divide   : restoring shift-subtract, {hi,lo} shifts left;
//                          lo collects quotient bits, hi ends as remainder.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_load          - capture operands, clear counter
//               i_step          - perform one iteration
//               i_is_div        - select divide step (held stable while busy)
//               i_a             - multiplier / dividend (magnitude)
//               i_b             - multiplicand / divisor (magnitude)
//               o_hi, o_lo      - raw partial registers
//               o_last          - current step is the final one
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mdu_seq_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_last
);
    localparam int                 c_CNT_W    = $clog2(ITER) + 1;
    // r_last is registered, so it is raised while the second-to-last step runs.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ITER - 2);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last;

    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_rem_sh_low;
    logic [WIDTH-1:0]   w_diff;
    logic               w_borrow;
    logic               w_fits;

    // Multiply: add multiplicand when the current multiplier bit is set.
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Divide: shifted remainder is WIDTH+1 bits; its top bit is r_hi[WIDTH-1].
    // If that bit is set the subtraction always fits, and the WIDTH-bit
    // difference is still exact because the true result is below the divisor.
    assign w_rem_sh_low       = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign {w_borrow, w_diff} = {1'b0, w_rem_sh_low} - {1'b0, r_b};
    assign w_fits             = r_hi[WIDTH-1] | ~w_borrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (i_load) begin
            r_hi   <= '0;
            r_lo   <= i_a;
            r_b    <= i_b;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (i_step) begin
            r_cnt  <= r_cnt + 1'b1;
            r_last <= (r_cnt == c_CNT_LAST);
            if (i_is_div) begin
                r_hi <= w_fits ? w_diff : w_rem_sh_low;
                r_lo <= {r_lo[WIDTH-2:0], w_fits};
            end else begin
                r_hi <= w_add[WIDTH:1];
                r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = r_last;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
//==============================================================================
// Module      : mult_div_unit
// Description : EX-stage multiply/divide unit owning HI/LO.
//               MULT/MULTU/DIV/DIVU run IDLE->CALC(ITER cycles)->FIX->IDLE;
//               divide by zero skips CALC. MTHI/MTLO write in IDLE;
//               MFHI/MFLO read combinationally on Result.
//               Stall = Busy & Start (the stalled op must be re-presented).
// Config      : FAST_MULT_EN - MULT/MULTU complete in one cycle from a
//               combinational product; divides keep the iterative path.
// Ports       : clk   - clock
//               rst_n - async active-low reset
//               bus   - mult_div_unit_if.slave (Start, Operation, DataA,
//                       DataB in; Busy, Done, Stall, Result out)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_is_div;
    logic               r_neg_lo;   // product or quotient is negative
    logic               r_neg_hi;   // remainder is negative (dividend sign)
    logic               r_div0;

    logic               w_idle;
    logic               w_busy;
    logic               w_core_step;
    logic               w_last;
    logic               w_is_md;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_accept_md;
    logic               w_iter_go;
    logic               w_div0;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_core_a;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH-1:0]   w_result;

    //--------------------------------------------------------------------------
    // Decode: bit1 of the funct selects divide, bit0 selects unsigned.
    //--------------------------------------------------------------------------
    assign w_is_md     = is_md_op(bus.Operation);
    assign w_is_div    = bus.Operation[1];
    assign w_is_signed = ~bus.Operation[0];
    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_accept_md = w_idle & bus.Start & w_is_md;

`ifdef FAST_MULT_EN
    logic               w_fast_go;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_fast_go   = w_accept_md & ~w_is_div;
    assign w_iter_go   = w_accept_md & w_is_div;
    // Sign/zero extension to 2*WIDTH makes the truncated product exact.
    assign w_ext_a     = {{WIDTH{w_is_signed & bus.DataA[WIDTH-1]}}, bus.DataA};
    assign w_ext_b     = {{WIDTH{w_is_signed & bus.DataB[WIDTH-1]}}, bus.DataB};
    assign w_fast_prod = w_ext_a * w_ext_b;
`else
    assign w_iter_go   = w_accept_md;
`endif

    //--------------------------------------------------------------------------
    // Operand conditioning. The most negative value maps to itself, which is
    // the correct unsigned magnitude.
    //--------------------------------------------------------------------------
    assign w_div0   = w_is_div & (bus.DataB == '0);
    assign w_neg_a  = w_is_signed & bus.DataA[WIDTH-1];
    assign w_neg_b  = w_is_signed & bus.DataB[WIDTH-1];
    assign w_mag_a  = w_neg_a ? (~bus.DataA + 1'b1) : bus.DataA;
    assign w_mag_b  = w_neg_b ? (~bus.DataB + 1'b1) : bus.DataB;
    // On divide by zero the core just parks the raw dividend for HI.
    assign w_core_a = w_div0 ? bus.DataA : w_mag_a;

    mdu_seq_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_iter_go),
        .i_step   (w_core_step),
        .i_is_div (r_is_div),
        .i_a      (w_core_a),
        .i_b      (w_mag_b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo),
        .o_last   (w_last)
    );

    //--------------------------------------------------------------------------
    // FSM: state register / next state / outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_iter_go) w_next = w_div0 ? c_ST_FIX : c_ST_CALC;
            c_ST_CALC: if (w_last)    w_next = c_ST_FIX;
            c_ST_FIX:                 w_next = c_ST_IDLE;
            default:                  w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = 1'b0;
        w_core_step = 1'b0;
        case (r_state)
            c_ST_CALC: begin
                w_busy      = 1'b1;
                w_core_step = 1'b1;
            end
            c_ST_FIX:  w_busy = 1'b1;
            default:   w_busy = 1'b0;
        endcase
    end

    //--------------------------------------------------------------------------
    // Sign capture at acceptance
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_iter_go) begin
            r_is_div <= w_is_div;
            r_neg_lo <= w_neg_a ^ w_neg_b;
            r_neg_hi <= w_neg_a;
            r_div0   <= w_div0;
        end
    end

    //--------------------------------------------------------------------------
    // Sign fix-up applied in FIX
    //--------------------------------------------------------------------------
    assign w_prod     = {w_core_hi, w_core_lo};
    assign w_prod_fix = r_neg_lo ? (~w_prod + 1'b1) : w_prod;

    always_comb begin
        w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fix[WIDTH-1:0];
        if (r_div0) begin
            w_fix_hi = w_core_lo;
            w_fix_lo = {WIDTH{c_DIV0_FILL}};
        end else if (r_is_div) begin
            w_fix_hi = r_neg_hi ? (~w_core_hi + 1'b1) : w_core_hi;
            w_fix_lo = r_neg_lo ? (~w_core_lo + 1'b1) : w_core_lo;
        end
    end

    //--------------------------------------------------------------------------
    // HI/LO and Done
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == c_ST_FIX) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
`ifdef FAST_MULT_EN
        end else if (w_fast_go) begin
            r_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_fast_prod[WIDTH-1:0];
`endif
        end else if (w_idle & bus.Start) begin
            if (bus.Operation == c_FUNCT_MTHI) r_hi <= bus.DataA;
            if (bus.Operation == c_FUNCT_MTLO) r_lo <= bus.DataA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
`ifdef FAST_MULT_EN
            r_done <= (r_state == c_ST_FIX) | w_fast_go;
`else
            r_done <= (r_state == c_ST_FIX);
`endif
        end
    end

    //--------------------------------------------------------------------------
    // Result / handshake outputs
    //--------------------------------------------------------------------------
    always_comb begin
        case (bus.Operation)
            c_FUNCT_MFHI: w_result = r_hi;
            c_FUNCT_MFLO: w_result = r_lo;
            default:      w_result = '0;
        endcase
    end

    assign bus.Result = w_result;
    assign bus.Busy   = w_busy;
    assign bus.Done   = r_done;
    assign bus.Stall  = w_busy & bus.Start;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
//==============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit.
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled in the same window. Honours FAST_MULT_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int WIDTH = 32;

`ifdef FAST_MULT_EN
    localparam int   c_MUL_BUSY   = 0;
    localparam int   c_T5_STALLS  = 0;
    localparam logic c_T5_DONE    = 1'b0;
`else
    localparam int   c_MUL_BUSY   = 33;
    localparam int   c_T5_STALLS  = 29;
    localparam logic c_T5_DONE    = 1'b1;
`endif
    localparam int   c_DIV_BUSY   = 33;
    localparam logic [5:0] c_FUNCT_ADD = 6'b100000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    mult_div_unit_if #(.WIDTH(WIDTH)) u_if ();

    mult_div_unit #(
        .WIDTH (WIDTH),
        .ITER  (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        u_if.Start     = 1'b0;
        u_if.Operation = c_FUNCT_MFHI;
        #1 check({tag, "_hi"}, u_if.Result, exp_hi);
        u_if.Operation = c_FUNCT_MFLO;
        #1 check({tag, "_lo"}, u_if.Result, exp_lo);
        u_if.Operation = 6'h00;
    endtask

    // Start in cycle N, count Busy cycles from N+1, expect Done right after.
    task automatic run_op(input string tag, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        u_if.Start     = 1'b1;
        u_if.Operation = op;
        u_if.DataA     = a;
        u_if.DataB     = b;
        tick();
        u_if.Start     = 1'b0;
        u_if.Operation = 6'h00;
        u_if.DataA     = '0;
        u_if.DataB     = '0;
        n = 0;
        while (u_if.Busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, n, exp_busy);
        check({tag, "_done"}, {31'd0, u_if.Done}, 32'd1);
        tick();
        check({tag, "_done_pulse"}, {31'd0, u_if.Done}, 32'd0);
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        int n;
        int ns;
        u_if.Start     = 1'b0;
        u_if.Operation = 6'h00;
        u_if.DataA     = '0;
        u_if.DataB     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        u_if.Start     = 1'b1;
        u_if.Operation = c_FUNCT_MULT;
        #1;
        check("rst_busy",  {31'd0, u_if.Busy},  32'd0);
        check("rst_done",  {31'd0, u_if.Done},  32'd0);
        check("rst_stall", {31'd0, u_if.Stall}, 32'd0);
        read_hilo("rst", 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();

        // MTHI / MTLO
        u_if.Start     = 1'b1;
        u_if.Operation = c_FUNCT_MTHI;
        u_if.DataA     = 32'h0000_1234;
        tick();
        check("mthi_busy", {31'd0, u_if.Busy}, 32'd0);
        u_if.Operation = c_FUNCT_MTLO;
        u_if.DataA     = 32'h0000_5678;
        tick();
        u_if.Start     = 1'b0;
        check("mt_done", {31'd0, u_if.Done}, 32'd0);
        read_hilo("mt", 32'h0000_1234, 32'h0000_5678);

        // Non-MF operation reads zero; unrecognised funct is ignored
        u_if.Operation = c_FUNCT_ADD;
        #1 check("result_other_op", u_if.Result, 32'h0);
        u_if.Start = 1'b1;
        u_if.DataA = 32'hDEAD_BEEF;
        u_if.DataB = 32'h1;
        tick();
        u_if.Start = 1'b0;
        check("ign_busy", {31'd0, u_if.Busy}, 32'd0);
        tick();
        check("ign_done", {31'd0, u_if.Done}, 32'd0);
        read_hilo("ign", 32'h0000_1234, 32'h0000_5678);

        // Arithmetic vectors
        run_op("multu_3x5",  c_FUNCT_MULTU, 32'd3,          32'd5,          c_MUL_BUSY, 32'h0,         32'd15);
        run_op("mult_m2x7",  c_FUNCT_MULT,  32'hFFFF_FFFE,  32'd7,          c_MUL_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        run_op("multu_max",  c_FUNCT_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  c_MUL_BUSY, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7d2",   c_FUNCT_DIV,   32'hFFFF_FFF9,  32'd2,          c_DIV_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2",   c_FUNCT_DIV,   32'd7,          32'hFFFF_FFFE,  c_DIV_BUSY, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_7d2",   c_FUNCT_DIVU,  32'd7,          32'd2,          c_DIV_BUSY, 32'h0000_0001, 32'h0000_0003);
        run_op("divu_big",   c_FUNCT_DIVU,  32'hFFFF_FFFF,  32'h10,         c_DIV_BUSY, 32'h0000_000F, 32'h0FFF_FFFF);
        run_op("div_9d0",    c_FUNCT_DIV,   32'd9,          32'd0,          1,          32'h0000_0009, 32'hFFFF_FFFF);
        run_op("div_min_m1", c_FUNCT_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  c_DIV_BUSY, 32'h0000_0000, 32'h8000_0000);
        run_op("div_m9d0",   c_FUNCT_DIV,   32'hFFFF_FFF7,  32'd0,          1,          32'hFFFF_FFF7, 32'hFFFF_FFFF);

        // MFHI presented at N+5 during a MULT stalls until Busy falls
        u_if.Start     = 1'b1;
        u_if.Operation = c_FUNCT_MULT;
        u_if.DataA     = 32'h0001_0000;
        u_if.DataB     = 32'h0003_0000;
        tick();
        u_if.Start     = 1'b0;
        u_if.Operation = 6'h00;
        repeat (4) tick();
        u_if.Start     = 1'b1;
        u_if.Operation = c_FUNCT_MFHI;
        #1;
        n  = 0;
        ns = 0;
        while (u_if.Busy === 1'b1 && n < 100) begin
            if (u_if.Stall === 1'b1) ns++;
            n++;
            tick();
        end
        check("stall_cycles",     n,  c_T5_STALLS);
        check("stall_every_busy", ns, c_T5_STALLS);
        check("stall_released",   {31'd0, u_if.Stall}, 32'd0);
        check("stall_done",       {31'd0, u_if.Done},  {31'd0, c_T5_DONE});
        check("stall_mfhi_new",   u_if.Result, 32'h0000_0003);
        // New op accepted in the Done cycle
        u_if.Operation = c_FUNCT_MTLO;
        u_if.DataA     = 32'h0000_0077;
        tick();
        u_if.Start     = 1'b0;
        read_hilo("done_cycle_mt", 32'h0000_0003, 32'h0000_0077);

        // Reset mid-DIV aborts and clears HI/LO
        u_if.Start     = 1'b1;
        u_if.Operation = c_FUNCT_DIV;
        u_if.DataA     = 32'd100;
        u_if.DataB     = 32'd7;
        tick();
        u_if.Start     = 1'b0;
        u_if.Operation = 6'h00;
        repeat (9) tick();
        check("pre_rst_busy", {31'd0, u_if.Busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, u_if.Busy}, 32'd0);
        read_hilo("abort", 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        n  = 0;
        ns = 0;
        repeat (40) begin
            tick();
            if (u_if.Done === 1'b1) n++;
            if (u_if.Busy === 1'b1) ns++;
        end
        check("abort_no_done", n,  0);
        check("abort_no_busy", ns, 0);

        // Recovery after abort
        run_op("divu_100d7", c_FUNCT_DIVU, 32'd100, 32'd7, c_DIV_BUSY, 32'h0000_0002, 32'h0000_000E);
        run_op("mult_6x7",   c_FUNCT_MULT, 32'd6,   32'd7, c_MUL_BUSY, 32'h0,         32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
